// File: rtl/breakout_engine.sv
// Game-state engine for the LED-matrix brick-breaker: paddle, ball, brick wall, lives, BCD score.
// Optional moving barrier row at y=ROWS/2 is compiled in with `define BREAKOUT_BARRIER_EN.
module breakout_engine #(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int BRICK_ROWS = 2,
  parameter int PLAT_W     = 3,
  parameter int BALL_DIV   = 3,
  parameter int LIVES      = 3
) (
  input  logic                      buttonclk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      left,
  input  logic                      right,
  input  logic                      throw,
  output logic [$clog2(COLS)-1:0]   plat_x,
  output logic [$clog2(COLS)-1:0]   ball_x,
  output logic [$clog2(ROWS)-1:0]   ball_y,
  output logic                      held,
  output logic [BRICK_ROWS*COLS-1:0] bricks,
  output logic [2:0]                lives,
  output logic [3:0]                score_ones,
  output logic [3:0]                score_tens,
  output logic                      game_over,
  output logic                      game_clear,
  output logic [COLS-1:0]           barrier
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int NB = BRICK_ROWS * COLS;
  localparam int CW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;

  typedef enum logic [1:0] {S_HELD, S_FLIGHT, S_OVER, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   plat_x_q, plat_x_d;
  logic [XW-1:0]   ball_x_q, ball_x_d;
  logic [YW-1:0]   ball_y_q, ball_y_d;
  logic [1:0]      dx_q, dx_d;
  logic            dy_up_q, dy_up_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NB-1:0]   bricks_q, bricks_d;
  logic [2:0]      lives_q, lives_d;
  logic [3:0]      ones_q, ones_d;
  logic [3:0]      tens_q, tens_d;
`ifdef BREAKOUT_BARRIER_EN
  logic [COLS-1:0] barrier_q, barrier_d;
`endif

  int              np, px, bx, by, dxi, nx, ny, ndx, bidx;
  logic            ndy_up, step, hit;
  logic [NB-1:0]   bmask;

  always_ff @(posedge buttonclk) begin
    if (reset) begin
      state_q   <= S_HELD;
      plat_x_q  <= XW'((COLS - PLAT_W) / 2);
      ball_x_q  <= XW'((COLS - PLAT_W) / 2 + PLAT_W / 2);
      ball_y_q  <= YW'(1);
      dx_q      <= '0;
      dy_up_q   <= 1'b1;
      cnt_q     <= '0;
      bricks_q  <= '1;
      lives_q   <= 3'(LIVES);
      ones_q    <= '0;
      tens_q    <= '0;
`ifdef BREAKOUT_BARRIER_EN
      barrier_q <= COLS'(3);
`endif
    end else begin
      state_q   <= state_d;
      plat_x_q  <= plat_x_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dx_q      <= dx_d;
      dy_up_q   <= dy_up_d;
      cnt_q     <= cnt_d;
      bricks_q  <= bricks_d;
      lives_q   <= lives_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
`ifdef BREAKOUT_BARRIER_EN
      barrier_q <= barrier_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    plat_x_d = plat_x_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d     = dx_q;
    dy_up_d  = dy_up_q;
    cnt_d    = cnt_q;
    bricks_d = bricks_q;
    lives_d  = lives_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
`ifdef BREAKOUT_BARRIER_EN
    barrier_d = barrier_q;
`endif
    px     = int'(plat_x_q);
    bx     = int'(ball_x_q);
    by     = int'(ball_y_q);
    dxi    = (dx_q == 2'b11) ? -1 : ((dx_q == 2'b01) ? 1 : 0);
    np     = px;
    nx     = bx;
    ny     = by;
    ndx    = dxi;
    ndy_up = dy_up_q;
    step   = 1'b0;
    hit    = 1'b0;
    bidx   = 0;
    bmask  = '0;

    if (start && (state_q == S_HELD || state_q == S_FLIGHT)) begin
      if (left && !right && px > 0)
        np = px - 1;
      else if (right && !left && px < COLS - PLAT_W)
        np = px + 1;
      plat_x_d = XW'(np);
    end

    if (start) begin
      case (state_q)
        S_HELD: begin
          // Parked ball follows the paddle centre on the same edge, even when thrown.
          ball_x_d = XW'(np + PLAT_W / 2);
          ball_y_d = YW'(1);
          if (throw) begin
            state_d = S_FLIGHT;
            dx_d    = '0;
            dy_up_d = 1'b1;
            cnt_d   = '0;
          end
        end
        S_FLIGHT: begin
          if (int'(cnt_q) == BALL_DIV - 1) begin
            cnt_d = '0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          if (step) begin
`ifdef BREAKOUT_BARRIER_EN
            barrier_d = ((barrier_q << 1) == '0) ? COLS'(3) : (barrier_q << 1);
`endif
            if (by == 1 && !dy_up_q) begin
              if (bx >= px && bx <= px + PLAT_W - 1) begin
                dy_up_d  = 1'b1;
                ball_y_d = YW'(2);
                if (bx == px)
                  dx_d = 2'b11;
                else if (bx == px + PLAT_W - 1)
                  dx_d = 2'b01;
              end else begin
                lives_d  = lives_q - 3'd1;
                dx_d     = '0;
                dy_up_d  = 1'b1;
                ball_x_d = XW'(np + PLAT_W / 2);
                ball_y_d = YW'(1);
                state_d  = (lives_q == 3'd1) ? S_OVER : S_HELD;
              end
            end else begin
              nx = bx + dxi;
              if (nx < 0 || nx > COLS - 1) begin
                ndx = -dxi;
                nx  = bx - dxi;
              end
              if (dy_up_q) begin
                if (by == ROWS - 1) begin
                  ndy_up = 1'b0;
                  ny     = by - 1;
                end else begin
                  ny = by + 1;
                end
              end else begin
                ny = by - 1;
              end
              if (ny >= ROWS - BRICK_ROWS) begin
                bidx  = (ROWS - 1 - ny) * COLS + nx;
                bmask = NB'(1) << bidx;
              end
              hit = (bricks_q & bmask) != '0;
              if (hit) begin
                // A hit bounces the ball back without advancing it vertically.
                bricks_d = bricks_q & ~bmask;
                ball_x_d = XW'(nx);
                dx_d     = 2'(ndx);
                dy_up_d  = !ndy_up;
                if (ones_q == 4'd9) begin
                  if (tens_q != 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                  end
                end else begin
                  ones_d = ones_q + 4'd1;
                end
                if ((bricks_q & ~bmask) == '0)
                  state_d = S_CLEAR;
              end
`ifdef BREAKOUT_BARRIER_EN
              else if (ny == ROWS / 2 && barrier_q[XW'(nx)]) begin
                ball_x_d = XW'(nx);
                dx_d     = 2'(ndx);
                dy_up_d  = !ndy_up;
              end
`endif
              else begin
                ball_x_d = XW'(nx);
                ball_y_d = YW'(ny);
                dx_d     = 2'(ndx);
                dy_up_d  = ndy_up;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign plat_x     = plat_x_q;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign held       = (state_q == S_HELD);
  assign bricks     = bricks_q;
  assign lives      = lives_q;
  assign score_ones = ones_q;
  assign score_tens = tens_q;
  assign game_over  = (state_q == S_OVER);
  assign game_clear = (state_q == S_CLEAR);
`ifdef BREAKOUT_BARRIER_EN
  assign barrier    = barrier_q;
`else
  assign barrier    = '0;
`endif

endmodule

// File: tb/tb_breakout_engine.sv
// Directed bench for breakout_engine at default parameters (barrier compiled out).
module tb_breakout_engine;
  localparam int W = 47;
  localparam logic [W-1:0] M_ALL    = '1;
  localparam logic [W-1:0] M_NOBALL = {3'b111, 6'b0, 38'h3F_FFFF_FFFF};

  logic        buttonclk = 1'b0;
  logic        reset = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0, throw = 1'b0;
  logic [2:0]  plat_x, ball_x, ball_y, lives;
  logic        held, game_over, game_clear;
  logic [15:0] bricks;
  logic [3:0]  score_ones, score_tens;
  logic [7:0]  barrier;

  logic [2*W-1:0] exp_q[$];
  string          name_q[$];
  int             checks = 0, errors = 0;

  int          e_plat, e_bx, e_by, e_lives, e_ones, e_dir, ft;
  logic        e_held, e_over;
  logic [15:0] e_bricks;

  breakout_engine dut (
    .buttonclk(buttonclk), .reset(reset), .start(start), .left(left), .right(right),
    .throw(throw), .plat_x(plat_x), .ball_x(ball_x), .ball_y(ball_y), .held(held),
    .bricks(bricks), .lives(lives), .score_ones(score_ones), .score_tens(score_tens),
    .game_over(game_over), .game_clear(game_clear), .barrier(barrier)
  );

  // Clock / watchdog
  always #5 buttonclk = ~buttonclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000ns");
    $fatal(1);
  end

  function automatic logic [W-1:0] exp_snap();
    return {3'(e_plat), 3'(e_bx), 3'(e_by), e_held, e_bricks, 3'(e_lives),
            4'(e_ones), 4'd0, e_over, 1'b0, 8'd0};
  endfunction

  // Driver tasks: each call is one tick; the expected outputs after that edge are queued.
  task automatic tick(input logic l, input logic r, input logic t, input logic s,
                      input logic rst, input logic [W-1:0] m, input string nm);
    @(negedge buttonclk);
    left = l; right = r; throw = t; start = s; reset = rst;
    exp_q.push_back({m, exp_snap()});
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    e_plat = 2; e_bx = 3; e_by = 1; e_held = 1'b1; e_bricks = 16'hFFFF;
    e_lives = 3; e_ones = 0; e_over = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, M_ALL, "reset");
  endtask

  task automatic do_throw();
    ft = 0; e_held = 1'b0; e_dir = 1;
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, M_ALL, "throw");
  endtask

  task automatic fly(input int n, input logic l, input logic r);
    for (int i = 0; i < n; i++) begin
      ft++;
      if (l && !r && e_plat > 0) e_plat--;
      else if (r && !l && e_plat < 5) e_plat++;
      if (ft % 3 == 0) e_by = e_by + e_dir;
      tick(l, r, 1'b0, 1'b1, 1'b0, M_ALL, "flight");
    end
  endtask

  task automatic brick_hit(input logic [15:0] bit_mask, input string nm);
    ft++;
    e_bricks = e_bricks & ~bit_mask; e_ones++; e_dir = -1;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL, nm);
  endtask

  // Scoreboard monitor
  logic [2*W-1:0] mon_e;
  logic [W-1:0]   mon_act, mon_m, mon_v;
  string          mon_nm;
  initial begin
    forever begin
      @(posedge buttonclk);
      #2;
      if (exp_q.size() > 0) begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        mon_m  = mon_e[2*W-1:W];
        mon_v  = mon_e[W-1:0];
        mon_act = {plat_x, ball_x, ball_y, held, bricks, lives, score_ones, score_tens,
                   game_over, game_clear, barrier};
        checks++;
        if (((mon_act ^ mon_v) & mon_m) !== '0) begin
          errors++;
          $display("FAIL %s: got %h required %h", mon_nm, mon_act & mon_m, mon_v & mon_m);
        end
      end
    end
  end

  initial begin
    do_reset();

    // Paddle: left to the wall, both buttons, start low, right to the wall.
    for (int i = 0; i < 4; i++) begin
      if (e_plat > 0) e_plat--;
      e_bx = e_plat + 1;
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL, "paddle_left");
    end
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL, "left_right");
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, M_ALL, "start_low");
    for (int i = 0; i < 7; i++) begin
      if (e_plat < 5) e_plat++;
      e_bx = e_plat + 1;
      tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL, "paddle_right");
    end

    // Game 1: throw, hit bit 11, bounce on paddle interior, hit bit 3.
    do_reset();
    do_throw();
    fly(14, 1'b0, 1'b0);
    brick_hit(16'h0800, "hit_bit11");
    fly(14, 1'b0, 1'b0);
    ft++; e_by = 2; e_dir = 1;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL, "bounce");
    fly(14, 1'b0, 1'b0);
    brick_hit(16'h0008, "hit_bit3");

    // Game 2: three misses down to game over.
    do_reset();
    do_throw();
    fly(14, 1'b0, 1'b0);
    brick_hit(16'h0800, "hit_bit11_g2");
    fly(3, 1'b0, 1'b1);
    fly(11, 1'b0, 1'b0);
    ft++; e_lives = 2; e_held = 1'b1; e_bx = 6; e_by = 1;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL, "miss1");

    do_throw();
    fly(14, 1'b0, 1'b0);
    brick_hit(16'h4000, "hit_bit14");
    fly(3, 1'b1, 1'b0);
    fly(11, 1'b0, 1'b0);
    ft++; e_lives = 1; e_held = 1'b1; e_bx = 3; e_by = 1;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL, "miss2");

    do_throw();
    fly(17, 1'b0, 1'b0);
    brick_hit(16'h0008, "hit_bit3_g2");
    fly(3, 1'b0, 1'b1);
    fly(14, 1'b0, 1'b0);
    ft++; e_lives = 0; e_held = 1'b0; e_over = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, M_NOBALL, "game_over");
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, M_NOBALL, "over_hold");
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, M_NOBALL, "over_hold2");
    do_reset();

    // Drain the scoreboard within a bounded number of edges.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge buttonclk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
